// File: rtl/pkt_sched_pkg.sv
// Shared types and constants for the capture/readout packet scheduler.
// Holds the FSM states, length encoding and default widths.
package pkt_sched_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 18;
  localparam int LEN_ZERO_MEANS = 256;
  localparam int CW = 9;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    PKT_DATA,
    PKT_GAP,
    TAIL
  } state_e;

  // A length field of 0 encodes the full 256-word packet.
  function automatic logic [CW-1:0] len_of(
    input logic [7:0] l
  );
    return (l == 8'd0) ? CW'(LEN_ZERO_MEANS)
                       : {1'b0, l};
  endfunction

endpackage

// File: rtl/pkt_sched_cnt.sv
// Loadable down-counter; expire flags the last cycle of a count.
// Load takes priority over decrement.
module pkt_sched_cnt #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expire_o = (cnt_q <= W'(1));

endmodule

// File: rtl/pkt_sched_ctrl.sv
// Capture an ADC buffer into external memory, then stream it out
// as gapped packets with a tail idle period and a done pulse.
module pkt_sched_ctrl
  import pkt_sched_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          capture_start,
  input  logic          capture_again,
  input  logic          self_test,
  input  logic [7:0]    pkt_gap,
  input  logic [7:0]    pkt_data_len,
  input  logic [7:0]    pkt_idle_len,
  input  logic          adc_valid,
  input  logic [DW-1:0] adc_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  output logic          out_sop,
  output logic          out_eop,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  state_e        state_q;
  logic [AW-1:0] waddr_q;
  logic [AW-1:0] raddr_q;
  logic          buf_valid_q;
  logic          first_q;
  logic          done_q;
  logic          ov_q;
  logic          sop_q;
  logic          eop_q;

  logic wr_en;
  logic last_w;
  logic last_a;
  logic pkt_end;
  logic d_ld, g_ld, t_ld;
  logic d_exp, g_exp, t_exp;

  assign wr_en   = (state_q == CAPTURE)
                 && (self_test || adc_valid);
  assign last_w  = (waddr_q == '1);
  assign last_a  = (raddr_q == '1);
  assign pkt_end = d_exp || last_a;

  always_comb begin
    d_ld = 1'b0;
    g_ld = 1'b0;
    t_ld = 1'b0;
    case (state_q)
      IDLE:
        d_ld = capture_again && !capture_start
             && buf_valid_q;
      CAPTURE:
        d_ld = wr_en && last_w;
      PKT_DATA: begin
        if (last_a) begin
          t_ld = (pkt_idle_len != 8'd0);
        end else if (d_exp) begin
          d_ld = (pkt_gap == 8'd0);
          g_ld = (pkt_gap != 8'd0);
        end
      end
      PKT_GAP:
        d_ld = g_exp;
      default: ;
    endcase
  end

  pkt_sched_cnt #(.W(CW)) u_dcnt (
    .clk      (clk),
    .rstn     (rstn),
    .load_i   (d_ld),
    .val_i    (len_of(pkt_data_len)),
    .dec_i    (state_q == PKT_DATA),
    .expire_o (d_exp)
  );

  pkt_sched_cnt #(.W(CW)) u_gcnt (
    .clk      (clk),
    .rstn     (rstn),
    .load_i   (g_ld),
    .val_i    ({1'b0, pkt_gap}),
    .dec_i    (state_q == PKT_GAP),
    .expire_o (g_exp)
  );

  pkt_sched_cnt #(.W(CW)) u_tcnt (
    .clk      (clk),
    .rstn     (rstn),
    .load_i   (t_ld),
    .val_i    ({1'b0, pkt_idle_len}),
    .dec_i    (state_q == TAIL),
    .expire_o (t_exp)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      waddr_q     <= '0;
      raddr_q     <= '0;
      buf_valid_q <= 1'b0;
      first_q     <= 1'b0;
      done_q      <= 1'b0;
      ov_q        <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ov_q   <= (state_q == PKT_DATA);
      sop_q  <= (state_q == PKT_DATA) && first_q;
      eop_q  <= (state_q == PKT_DATA) && pkt_end;
      case (state_q)
        IDLE: begin
          if (capture_start) begin
            state_q     <= CAPTURE;
            waddr_q     <= '0;
            buf_valid_q <= 1'b0;
          end else if (capture_again && buf_valid_q) begin
            state_q <= PKT_DATA;
            raddr_q <= '0;
            first_q <= 1'b1;
          end
        end
        CAPTURE: begin
          if (wr_en) begin
            if (last_w) begin
              state_q     <= PKT_DATA;
              buf_valid_q <= 1'b1;
              raddr_q     <= '0;
              first_q     <= 1'b1;
            end else begin
              waddr_q <= waddr_q + AW'(1);
            end
          end
        end
        PKT_DATA: begin
          first_q <= 1'b0;
          if (last_a) begin
            if (pkt_idle_len == 8'd0) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= TAIL;
            end
          end else begin
            raddr_q <= raddr_q + AW'(1);
            if (d_exp) begin
              if (pkt_gap == 8'd0) first_q <= 1'b1;
              else state_q <= PKT_GAP;
            end
          end
        end
        PKT_GAP: begin
          if (g_exp) begin
            state_q <= PKT_DATA;
            first_q <= 1'b1;
          end
        end
        TAIL: begin
          if (t_exp) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_we    = wr_en;
  assign mem_waddr = waddr_q;
  assign mem_wdata = !wr_en   ? '0
                   : self_test ? DW'(waddr_q)
                   : adc_data;
  assign mem_re    = (state_q == PKT_DATA);
  assign mem_raddr = raddr_q;
  assign out_valid = ov_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;
  assign out_data  = ov_q ? mem_rdata : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_pkt_sched_ctrl.sv
// Randomized bench for pkt_sched_ctrl with AW=4 and an external RAM.
// Expected streams come from a packet-list model of the buffer.
`timescale 1ns/1ps
module tb_pkt_sched_ctrl;

  localparam int AW = 4;
  localparam int DW = 18;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          capture_start = 1'b0;
  logic          capture_again = 1'b0;
  logic          self_test = 1'b0;
  logic [7:0]    pkt_gap = '0;
  logic [7:0]    pkt_data_len = '0;
  logic [7:0]    pkt_idle_len = '0;
  logic          adc_valid = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          out_valid;
  logic          out_sop;
  logic          out_eop;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  pkt_sched_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .capture_start (capture_start),
    .capture_again (capture_again),
    .self_test     (self_test),
    .pkt_gap       (pkt_gap),
    .pkt_data_len  (pkt_data_len),
    .pkt_idle_len  (pkt_idle_len),
    .adc_valid     (adc_valid),
    .adc_data      (adc_data),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .mem_re        (mem_re),
    .mem_raddr     (mem_raddr),
    .mem_rdata     (mem_rdata),
    .out_valid     (out_valid),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .out_data      (out_data),
    .busy          (busy),
    .done          (done)
  );

  initial forever #5 clk = ~clk;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] rdata_q = '0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
    if (mem_re) rdata_q <= ram[mem_raddr];
  end
  assign mem_rdata = rdata_q;

  typedef struct {
    int            cyc;
    logic          sop;
    logic          eop;
    logic [DW-1:0] d;
  } ev_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } we_t;

  int  cyc = 0;
  ev_t outq[$];
  we_t weq[$];
  int  done_cnt = 0;
  int  done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid)
      outq.push_back('{cyc, out_sop, out_eop, out_data});
    if (mem_we)
      weq.push_back('{cyc, mem_waddr, mem_wdata});
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] ebuf [DEPTH];
  logic [DW-1:0] drv[$];

  task automatic run_op(input bit do_start,
                        input bit do_again,
                        input bit st,
                        input int vmode,
                        input logic [7:0] len,
                        input logic [7:0] gap,
                        input logic [7:0] idle,
                        input bit again_mid);
    ev_t ex[$];
    int  a, t, n, l, exp_done, m;
    outq.delete();
    weq.delete();
    drv.delete();
    done_cnt = 0;
    self_test = st;
    pkt_data_len = len;
    pkt_gap = gap;
    pkt_idle_len = idle;
    @(posedge clk); #1;
    capture_start = do_start;
    capture_again = do_again;
    adc_valid = 1'b0;
    @(posedge clk); #1;
    capture_start = 1'b0;
    capture_again = 1'b0;
    for (int k = 0; k < 2000 && done_cnt == 0; k++) begin
      case (vmode)
        0: adc_valid = 1'b1;
        1: adc_valid = (k % 2 == 0);
        default: adc_valid = 1'($urandom_range(0, 1));
      endcase
      adc_data = DW'($urandom);
      capture_again = again_mid && !do_start && (k == 5);
      if (adc_valid) drv.push_back(adc_data);
      @(posedge clk); #1;
    end
    chk("timeout", 64'(done_cnt > 0), 64'(1));
    capture_again = 1'b0;
    adc_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    // Buffer model: self-test counts, else first 16 strobed samples.
    if (do_start) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (st) ebuf[i] = DW'(i);
        else ebuf[i] = (i < drv.size()) ? drv[i] : '0;
      end
    end
    chk("nwe", 64'(weq.size()), 64'(do_start ? DEPTH : 0));
    m = (weq.size() < DEPTH) ? weq.size() : DEPTH;
    for (int i = 0; i < m; i++) begin
      chk($sformatf("we%0d_a", i), 64'(weq[i].a), 64'(i));
      chk($sformatf("we%0d_d", i), 64'(weq[i].d),
          64'(ebuf[i]));
    end
    if (do_start && vmode == 1 && weq.size() == DEPTH)
      chk("we_span", 64'(weq[DEPTH-1].cyc - weq[0].cyc),
          64'(2 * (DEPTH - 1)));
    l = (len == 8'd0) ? 256 : int'(len);
    a = 0;
    t = 0;
    while (a < DEPTH) begin
      n = (DEPTH - a < l) ? DEPTH - a : l;
      for (int k = 0; k < n; k++) begin
        ex.push_back('{t, k == 0, k == n - 1, ebuf[a]});
        a++;
        t++;
      end
      if (a < DEPTH) t += int'(gap);
    end
    exp_done = (t - 1) + int'(idle);
    chk("nout", 64'(outq.size()), 64'(ex.size()));
    m = (outq.size() < ex.size()) ? outq.size() : ex.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("o%0d_d", i), 64'(outq[i].d),
          64'(ex[i].d));
      chk($sformatf("o%0d_se", i),
          64'({outq[i].sop, outq[i].eop}),
          64'({ex[i].sop, ex[i].eop}));
      chk($sformatf("o%0d_t", i),
          64'(outq[i].cyc - outq[0].cyc), 64'(ex[i].cyc));
    end
    if (do_start && outq.size() > 0 && weq.size() > 0)
      chk("lat", 64'(outq[0].cyc - weq[weq.size()-1].cyc),
          64'(2));
    chk("ndone", 64'(done_cnt), 64'(1));
    if (outq.size() > 0)
      chk("done_t", 64'(done_cyc - outq[0].cyc),
          64'(exp_done));
    chk("busy_end", 64'(busy), 64'(0));
  endtask

  logic [7:0] lens [8];

  initial begin
    lens[0] = 8'd1;  lens[1] = 8'd3;
    lens[2] = 8'd4;  lens[3] = 8'd5;
    lens[4] = 8'd7;  lens[5] = 8'd0;
    lens[6] = 8'd16; lens[7] = 8'd200;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_ov", 64'(out_valid), 64'(0));
    chk("rst_we", 64'(mem_we), 64'(0));
    chk("rst_re", 64'(mem_re), 64'(0));
    chk("rst_se", 64'({out_sop, out_eop}), 64'(0));
    rstn = 1'b1;

    // Replay request with no captured buffer is dropped.
    outq.delete();
    @(posedge clk); #1;
    capture_again = 1'b1;
    @(posedge clk); #1;
    capture_again = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("nobuf_busy", 64'(busy), 64'(0));
    chk("nobuf_out", 64'(outq.size()), 64'(0));

    run_op(1, 0, 1, 2, 8'd4, 8'd2, 8'd3, 0);
    run_op(0, 1, 1, 2, 8'd4, 8'd2, 8'd3, 1);
    run_op(0, 1, 1, 2, 8'd0, 8'd2, 8'd3, 0);
    run_op(0, 1, 1, 2, 8'd5, 8'd1, 8'd0, 0);
    run_op(1, 0, 0, 1, 8'd4, 8'd0, 8'd1, 0);
    run_op(1, 1, 0, 0, 8'd3, 8'd1, 8'd2, 0);

    for (int r = 0; r < 6; r++) begin
      run_op(1, 0, 1'($urandom_range(0, 1)), 2,
             lens[$urandom_range(0, 7)],
             8'($urandom_range(0, 3)),
             8'($urandom_range(0, 3)), 0);
      run_op(0, 1, 1'b0, 2,
             lens[$urandom_range(0, 7)],
             8'($urandom_range(0, 3)),
             8'($urandom_range(0, 3)), 0);
    end

    // Reset during readout discards the buffer.
    pkt_data_len = 8'd4;
    pkt_gap = 8'd1;
    pkt_idle_len = 8'd1;
    @(posedge clk); #1;
    capture_again = 1'b1;
    @(posedge clk); #1;
    capture_again = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_re", 64'(mem_re), 64'(0));
    chk("arst_ov", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    outq.delete();
    capture_again = 1'b1;
    @(posedge clk); #1;
    capture_again = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("post_rst_out", 64'(outq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pkt_sched_ctrl.md
PKT_SCHED_CTRL -- requirements
Module: pkt_sched_ctrl

Interface
REQ-001 Parameter AW, default 12: capture-buffer address width; DEPTH = 2**AW samples.
REQ-002 Parameter DW, default 18: ADC sample width.
REQ-003 clk  in  1  sole clock; all logic is on its rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 capture_start  in  1  single-cycle pulse: capture a new buffer, then read it out.
REQ-006 capture_again  in  1  single-cycle pulse: read out the existing buffer again, with no recapture.
REQ-007 self_test  in  1  when 1, the write data comes from an internal counter instead of the ADC.
REQ-008 pkt_gap  in  8  number of idle cycles between packets.
REQ-009 pkt_data_len  in  8  words per packet; 0 means 256.
REQ-010 pkt_idle_len  in  8  tail idle cycles after the last packet.
REQ-011 adc_valid  in  1  ADC sample strobe.
REQ-012 adc_data  in  DW  ADC sample.
REQ-013 mem_we / mem_waddr / mem_wdata  out  1/AW/DW  buffer write port.
REQ-014 mem_re / mem_raddr  out  1/AW  buffer read port.
REQ-015 mem_rdata  in  DW  buffer read data, valid one cycle after mem_re.
REQ-016 out_valid / out_sop / out_eop / out_data  out  1/1/1/DW  packet stream.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse at the end of the readout tail.

Function
REQ-019 The FSM SHALL have the states IDLE, CAPTURE, PKT_DATA, PKT_GAP and TAIL.
REQ-020 IDLE: capture_start SHALL go to CAPTURE with the write address cleared; otherwise capture_again, when buf_valid=1, SHALL go to PKT_DATA with the read address cleared; if both pulses occur in the same cycle, start wins.
REQ-021 Start and again pulses received outside IDLE SHALL be ignored; they are not queued.
REQ-022 CAPTURE, self_test=0: each cycle with adc_valid=1 SHALL write adc_data to mem_waddr and increment the address.
REQ-023 CAPTURE, self_test=1: a write SHALL occur every cycle with mem_wdata = write address zero-extended to DW; adc_valid is ignored.
REQ-024 After writing address DEPTH-1, the FSM SHALL set buf_valid=1, clear the read address and go to PKT_DATA.
REQ-025 PKT_DATA SHALL assert mem_re for one address per cycle; at L words issued, or at address DEPTH-1, it SHALL go to PKT_GAP when addresses remain, else to TAIL.
REQ-026 L SHALL equal pkt_data_len, with 0 meaning 256.
REQ-027 The final packet SHALL be truncated when DEPTH is not a multiple of L.
REQ-028 PKT_GAP SHALL hold for pkt_gap cycles and then return to PKT_DATA; pkt_gap=0 SHALL mean no gap cycles, so packets are back-to-back.
REQ-029 TAIL SHALL hold for pkt_idle_len cycles (0 means none), then pulse done and return to IDLE.
REQ-030 out_valid / out_data SHALL be mem_re / mem_rdata delayed one cycle, giving a fixed latency of 1 from mem_re to output.
REQ-031 out_sop SHALL mark the first word of each packet and out_eop the last word, both aligned with out_valid; for a 1-word packet both SHALL be high together.
REQ-032 Configuration inputs SHALL be sampled at each packet start and at entry to PKT_GAP or TAIL; changes mid-count SHALL not affect the count in progress.
REQ-033 All counters SHALL be wide enough that there is no wrap-around inside a count; the address does not wrap past DEPTH-1.

Reset
REQ-034 Asynchronous assertion of rstn SHALL force: state IDLE, all counters 0, buf_valid 0, and all outputs 0.
REQ-035 Reset asserted mid-capture or mid-readout SHALL discard the operation; buf_valid SHALL be 0 afterwards.

Structure
REQ-036 A shared package pkt_sched_pkg SHALL hold the FSM state enum, the constant LEN_ZERO_MEANS = 256, and the default AW and DW.
REQ-037 One sub-module, pkt_sched_cnt, SHALL be instantiated for the three down-counters (data, gap and idle), each with load and expire ports.
REQ-038 The buffer memory SHALL be external to this block.

Verification
REQ-039 AW=4, self_test=1, len=4, gap=2, idle=3, start pulse -> 16 writes with data 0..15, then 4 packets of 4 words, 2 idle cycles between packets, done 3 cycles after the last eop.
REQ-040 After REQ-039, capture_again -> identical output stream with no mem_we; a second again pulse during readout -> ignored.
REQ-041 AW=4, len=0 -> a single 16-word packet, sop on word 0 and eop on word 15; len=5 -> packets of 5, 5, 5, 1 words, with sop and eop both high on the final word.
REQ-042 self_test=0 with adc_valid toggling every other cycle -> 16 writes spread over 32 cycles, mem_wdata equal to adc_data.
REQ-043 Reset in the middle of PKT_DATA, then capture_again -> stays in IDLE (buf_valid=0), with no output.
REQ-044 Start and again pulsed in the same cycle from IDLE with buf_valid=1 -> CAPTURE is entered.
